rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares the 16:1 select datapath among 16 requesters.
- Drives the 4-bit select bus of the downstream 16:1 mux, plus a one-hot grant back to the requesters.
- Holds each grant until the owner signals done or drops its request.
- Sits between the requester bank and the mux select input.

Parameters:
- N, 16, number of requesters (mux data width).
- SW, 4, select width; must equal clog2(N).
- TIMEOUT, 64, maximum grant-hold cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- done  input  1  single-cycle release pulse from the current owner.
- sel  output  SW  registered mux select; index of the current owner.
- gnt  output  N  registered one-hot grant; all zero when idle.
- busy  output  1  high while a grant is held.
- timeout  output  1  single-cycle pulse on forced release (optional feature only; tied 0 otherwise).

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high on rst, sampled at the clk rising edge.
- Reset values: sel=0, gnt=0, busy=0, timeout=0, priority pointer ptr=0, state=IDLE.
- States: IDLE, GRANT.
- IDLE, req==0: stay in IDLE; outputs hold their idle values (gnt=0, busy=0; sel retains its last value).
- IDLE, req!=0: pick winner w = the first set bit of req scanning ptr, ptr+1, ... wrapping mod N.
  - Next edge: sel=w, gnt=1<<w, busy=1, state=GRANT, ptr=(w+1) mod N.
  - Latency: req sampled at edge t gives grant visible after edge t+1.
- GRANT: sel and gnt hold stable; new or dropped requests from other indices are ignored.
- Release condition (evaluated in GRANT): done==1, or req[sel]==0 (owner abandoned). Both together count as a single release.
  - Next edge: gnt=0, busy=0, state=IDLE; sel keeps its last value.
- Turnaround: exactly one idle cycle between consecutive grants. Minimum grant is 1 cycle (release in the first GRANT cycle).
- done while in IDLE: ignored.
- Wrap-around: ptr=15 with winner 15 gives ptr=0. If only the last owner requests, it wins again after the idle cycle.
- Fairness: with all N requesting continuously, grants go 0,1,...,15,0,...
- rst asserted mid-grant: reset values apply at that edge; the grant is dropped with no timeout pulse.
- sel must never change while busy=1 (glitch-free mux selection for the owner).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each grant and increments every GRANT cycle.
  - When it reaches TIMEOUT-1 without a release, the next edge forces release (gnt=0, busy=0, IDLE) and timeout=1 for one cycle.
  - A normal release in the same cycle takes precedence; timeout stays 0.
  - ptr advances normally, so the hog loses priority.
- Undefined: no counter; a grant is held indefinitely until release; timeout is tied 0.

Decomposition:
- Package arb_pkg:
  - constants N=16 and SW=4;
  - state enum {IDLE, GRANT};
  - typedefs req_t (logic [N-1:0]) and sel_t (logic [SW-1:0]).
- Sub-module rr_pick: purely combinational rotate-priority finder.
  - Inputs: req, ptr.
  - Outputs: any, idx (SW bits).
  - Instantiated once inside rr_mux_arbiter.

Test Plan:
- Reset, then req=16'h0000 for 10 cycles -> gnt=0, busy=0, sel=0 throughout.
- req=16'h0020 held, done pulsed 3 cycles after grant -> sel=5, gnt=16'h0020 one cycle after req; busy falls the edge after done; one idle cycle, then re-grant to 5.
- req=16'hFFFF constant, done every grant cycle -> grant sequence 0,1,2,...,15,0, with one idle cycle between grants.
- ptr=15 (after granting 14), req=16'h4001 -> grants 0 then 14 (wrap-around order).
- Grant to 3, then drop req[3] with done=0 -> release next edge; rst asserted mid-grant on a later grant to 7 -> all outputs zero at that edge, ptr=0.
- ARB_TIMEOUT_EN with TIMEOUT=8, req=16'h0101, no done -> grant 0 held 8 cycles, timeout pulse, then grant 8.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Optional feature macro used by this slice: ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int N  = 16;
    localparam int SW = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef logic [N-1:0]  req_t;
    typedef logic [SW-1:0] sel_t;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/arbiter bus: request vector and release pulse in,
// registered mux select, one-hot grant, busy and timeout out.
interface rr_mux_arbiter_if;
    import arb_pkg::*;

    req_t req;
    logic done;
    sel_t sel;
    req_t gnt;
    logic busy;
    logic timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  gnt,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output gnt,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority finder: returns the first set request bit found
// when scanning ptr, ptr+1, ... wrapping modulo N.
module rr_pick
    import arb_pkg::*;
(
    input  req_t req,
    input  sel_t ptr,
    output logic any,
    output sel_t idx
);

    sel_t cand;

    // Scan from the farthest offset back to ptr so the nearest hit wins last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + sel_t'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// Grants are held until done or the owner drops its request.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module rr_mux_arbiter
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 64
)
`endif
(
    input  logic           clk,
    input  logic           rst,
    rr_mux_arbiter_if.slave bus
);

    state_t state;
    sel_t   ptr;
    sel_t   sel_q;
    req_t   gnt_q;
    logic   busy_q;
    logic   pick_any;
    sel_t   pick_idx;
    logic   release_now;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign release_now = bus.done || !bus.req[sel_q];

    assign bus.sel  = sel_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef logic [CW-1:0] cnt_t;

    cnt_t hold_cnt;
    logic timeout_q;

    assign bus.timeout = timeout_q;

    // Arbitration FSM with hold counter; a normal release beats the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q    <= pick_idx;
                        gnt_q    <= req_t'(1) << pick_idx;
                        busy_q   <= 1'b1;
                        ptr      <= pick_idx + sel_t'(1);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (hold_cnt == cnt_t'(TIMEOUT - 1)) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + cnt_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign bus.timeout = 1'b0;

    // Arbitration FSM: pick in IDLE, hold the grant until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            sel_q  <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q  <= pick_idx;
                        gnt_q  <= req_t'(1) << pick_idx;
                        busy_q <= 1'b1;
                        ptr    <= pick_idx + sel_t'(1);
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
